// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared write-back types for the FPU subsystem
package fpu_ss_pkg;

  localparam int unsigned FpFlen = 32;

  typedef enum logic {
    WbFpu = 1'b0,
    WbMem = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [4:0]        rd;
    logic [FpFlen-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// rtl/fpu_ss_wb_fifo.sv - small synchronous FIFO holding load responses that lost arbitration
module fpu_ss_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// rtl/fpu_ss_wb_arbiter.sv - shares the FPR write port between FPnew results and load responses
module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned MEM_BUF_DEPTH = 2,
  parameter int unsigned MAX_STALL     = 3,
  parameter int unsigned FLEN          = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           fpu_valid_i,
  output logic                           fpu_ready_o,
  input  logic [4:0]                     fpu_rd_i,
  input  logic [FLEN-1:0]                fpu_data_i,
  input  logic                           mem_valid_i,
  input  logic [4:0]                     mem_rd_i,
  input  logic [FLEN-1:0]                mem_data_i,
  output logic                           fpr_we_o,
  output logic [4:0]                     fpr_waddr_o,
  output logic [FLEN-1:0]                fpr_wdata_o,
  output logic                           fpr_wsrc_o,
  output logic                           sb_clr_o,
  output logic                           mem_buf_full_o,
  output logic [$clog2(MEM_BUF_DEPTH):0] mem_buf_cnt_o,
  output logic                           overflow_o
);

  localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

  logic [FLEN+4:0]    buf_rdata;
  logic               buf_empty, buf_full;
  logic               mem_cand, fpu_gnt, mem_gnt;
  logic               push, pop;
  logic [4:0]         mem_rd;
  logic [FLEN-1:0]    mem_data;
  logic [STALL_W-1:0] stall_q;
  logic               overflow_q;
  wb_src_e            wsrc;

  fpu_ss_wb_fifo #(
    .DEPTH (MEM_BUF_DEPTH),
    .WIDTH (FLEN + 5)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata ({mem_rd_i, mem_data_i}),
    .pop   (pop),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (mem_buf_cnt_o)
  );

  // Buffered responses are older than the incoming one, so the FIFO head has priority.
  assign mem_rd   = buf_empty ? mem_rd_i   : buf_rdata[FLEN+4:FLEN];
  assign mem_data = buf_empty ? mem_data_i : buf_rdata[FLEN-1:0];

  always_comb begin
    mem_cand    = rst_ni & (~buf_empty | mem_valid_i);
    fpu_gnt     = rst_ni & fpu_valid_i & (~mem_cand | (stall_q == STALL_LIMIT));
    mem_gnt     = mem_cand & ~fpu_gnt;
    wsrc        = WbFpu;
    fpr_waddr_o = '0;
    fpr_wdata_o = '0;
    if (fpu_gnt) begin
      fpr_waddr_o = fpu_rd_i;
      fpr_wdata_o = fpu_data_i;
    end else if (mem_gnt) begin
      wsrc        = WbMem;
      fpr_waddr_o = mem_rd;
      fpr_wdata_o = mem_data;
    end
  end

  assign fpr_we_o       = fpu_gnt | mem_gnt;
  assign sb_clr_o       = fpr_we_o;
  assign fpr_wsrc_o     = wsrc;
  assign fpu_ready_o    = fpu_gnt;
  assign mem_buf_full_o = buf_full;
  assign overflow_o     = overflow_q;
  assign push           = mem_valid_i & ~(buf_empty & mem_gnt);
  assign pop            = ~buf_empty & mem_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fpu_valid_i && !fpu_gnt)
        stall_q <= (stall_q == STALL_LIMIT) ? stall_q : stall_q + 1'b1;
      else
        stall_q <= '0;
      if (push && buf_full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// tb/tb_fpu_ss_wb_arbiter.sv - self-checking bench against a queue-based write-back model
module tb_fpu_ss_wb_arbiter;

  localparam int MS    = 3;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fpu_valid_i = 1'b0, mem_valid_i = 1'b0;
  logic [4:0]  fpu_rd_i = '0, mem_rd_i = '0;
  logic [31:0] fpu_data_i = '0, mem_data_i = '0;

  logic        fpu_ready_o, fpr_we_o, fpr_wsrc_o, sb_clr_o, mem_buf_full_o, overflow_o;
  logic [4:0]  fpr_waddr_o;
  logic [31:0] fpr_wdata_o;
  logic [1:0]  mem_buf_cnt_o;

  logic        z_ready, z_we, z_wsrc, z_sbclr, z_full, z_ovf;
  logic [4:0]  z_waddr;
  logic [31:0] z_wdata;
  logic [1:0]  z_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  logic [31:0] dropped[$];
  int          m_stall;
  logic        m_ovf;

  logic [44:0] exp_vec, obs_vec;
  logic        e_ready;
  logic        obs_we, obs_wsrc, obs_ready, obs_full, obs_ovf;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;
  logic [1:0]  obs_cnt;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o), .fpr_wsrc_o(fpr_wsrc_o),
    .sb_clr_o(sb_clr_o), .mem_buf_full_o(mem_buf_full_o), .mem_buf_cnt_o(mem_buf_cnt_o),
    .overflow_o(overflow_o)
  );

  fpu_ss_wb_arbiter #(.MEM_BUF_DEPTH(2), .MAX_STALL(0), .FLEN(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(z_ready), .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .fpr_we_o(z_we), .fpr_waddr_o(z_waddr), .fpr_wdata_o(z_wdata), .fpr_wsrc_o(z_wsrc),
    .sb_clr_o(z_sbclr), .mem_buf_full_o(z_full), .mem_buf_cnt_o(z_cnt), .overflow_o(z_ovf)
  );

  task automatic model_reset();
    mq.delete();
    dropped.delete();
    m_stall = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock cycle: drive, predict, sample, then retire the cycle in the model.
  task automatic step(input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic        mcand, fwin, mwin, was_empty, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    fpu_valid_i = fv; fpu_rd_i = frd; fpu_data_i = fd;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;
    #2;
    was_empty = (mq.size() == 0);
    mcand     = !was_empty || mv;
    fwin      = fv && (!mcand || m_stall == MS);
    mwin      = mcand && !fwin;
    e_we      = fwin || mwin;
    e_ready   = fwin;
    e_rd      = '0;
    e_data    = '0;
    if (fwin) begin
      e_rd = frd; e_data = fd;
    end else if (mwin) begin
      if (!was_empty) begin e_rd = mq[0].rd; e_data = mq[0].data; end
      else begin e_rd = mrd; e_data = md; end
    end
    exp_vec = {e_we, e_we, e_rd, e_data, mwin, fwin, 2'(mq.size()), (mq.size() == DEPTH), m_ovf};
    obs_vec = {fpr_we_o, sb_clr_o, fpr_waddr_o, fpr_wdata_o, fpr_wsrc_o, fpu_ready_o,
               mem_buf_cnt_o, mem_buf_full_o, overflow_o};
    obs_we = fpr_we_o; obs_waddr = fpr_waddr_o; obs_wdata = fpr_wdata_o; obs_wsrc = fpr_wsrc_o;
    obs_ready = fpu_ready_o; obs_cnt = mem_buf_cnt_o; obs_full = mem_buf_full_o; obs_ovf = overflow_o;
    @(posedge clk);
    if (mwin && !was_empty) void'(mq.pop_front());
    if (mv && !(mwin && was_empty)) begin
      if (mq.size() < DEPTH) mq.push_back(ent_t'({mrd, md}));
      else begin m_ovf = 1'b1; dropped.push_back(md); end
    end
    m_stall = (fv && !fwin) ? ((m_stall < MS) ? m_stall + 1 : MS) : 0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    fpu_valid_i = 1'b0; mem_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    fpu_valid_i = 1'b1; mem_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_checks++;
    if ({fpr_we_o, fpu_ready_o, mem_buf_full_o, mem_buf_cnt_o, overflow_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_main: got %b expected 000000", {fpr_we_o, fpu_ready_o, mem_buf_full_o, mem_buf_cnt_o, overflow_o});
    end
    n_checks++;
    if ({z_we, z_ready, z_full, z_cnt, z_ovf} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_stall0: got %b expected 000000", {z_we, z_ready, z_full, z_cnt, z_ovf});
    end
    apply_reset();
  endtask

  task automatic test_lone_load();
    apply_reset();
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h3F800000);
    n_checks++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL lone_load_vec: got %h expected %h", obs_vec, exp_vec); end
    n_checks++;
    if ({obs_we, obs_waddr, obs_wsrc, obs_wdata} !== {1'b1, 5'd5, 1'b1, 32'h3F800000}) begin
      n_fail++;
      $display("FAIL lone_load_port: got %h expected %h", {obs_we, obs_waddr, obs_wsrc, obs_wdata}, {1'b1, 5'd5, 1'b1, 32'h3F800000});
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (obs_cnt !== 2'd0) begin n_fail++; $display("FAIL lone_load_cnt: got %0d expected 0", obs_cnt); end
  endtask

  task automatic test_collision();
    logic accepted = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(!accepted, 5'd2, 32'hC0000000, 1'b1, 5'd7, 32'h7000 + i);
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL collision_vec cyc%0d: got %h expected %h", i, obs_vec, exp_vec); end
      n_checks++;
      if (obs_ready !== (i == 3)) begin n_fail++; $display("FAIL collision_ready cyc%0d: got %b expected %b", i, obs_ready, (i == 3)); end
      if (obs_ready) accepted = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL collision_drain%0d: got %h expected %h", i, obs_vec, exp_vec); end
    end
    // stall counter restarted from 0, so a fresh collision goes to memory
    step(1'b1, 5'd2, 32'h1, 1'b1, 5'd7, 32'h2);
    n_checks++;
    if ({obs_ready, obs_wsrc} !== 2'b01) begin n_fail++; $display("FAIL collision_restart: got %b expected 01", {obs_ready, obs_wsrc}); end
  endtask

  task automatic test_buffering();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 5'd2, 32'hABCD, 1'b1, 5'd7, 32'h70 + i);
    step(1'b1, 5'd2, 32'hABCD, 1'b1, 5'd9, 32'h9999);
    n_checks++;
    if ({obs_ready, obs_waddr} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL buffering_fpu_win: got %h expected %h", {obs_ready, obs_waddr}, {1'b1, 5'd2}); end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if ({obs_cnt, obs_we, obs_waddr, obs_wsrc, obs_wdata} !== {2'd1, 1'b1, 5'd9, 1'b1, 32'h9999}) begin
      n_fail++;
      $display("FAIL buffering_drain: got %h expected %h", {obs_cnt, obs_we, obs_waddr, obs_wsrc, obs_wdata}, {2'd1, 1'b1, 5'd9, 1'b1, 32'h9999});
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if ({obs_cnt, obs_we} !== 3'b000) begin n_fail++; $display("FAIL buffering_empty: got %b expected 000", {obs_cnt, obs_we}); end
  endtask

  task automatic test_full();
    logic [31:0] fd = 32'hF000;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 5'd3, fd, 1'b1, 5'(i), 32'h1000 + i);
      if (e_ready) fd++;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_vec cyc%0d: got %h expected %h", i, obs_vec, exp_vec); end
      if (i >= 9 && i <= 11) begin
        n_checks++;
        if ({obs_cnt, obs_full} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL full_pushpop cyc%0d: got %b expected 101", i, {obs_cnt, obs_full}); end
      end
      if (i == 11 || i == 12) begin
        n_checks++;
        if (obs_ovf !== (i == 12)) begin n_fail++; $display("FAIL full_overflow cyc%0d: got %b expected %b", i, obs_ovf, (i == 12)); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_drain_vec%0d: got %h expected %h", i, obs_vec, exp_vec); end
      if (obs_we && obs_wsrc) begin
        foreach (dropped[k]) begin
          n_checks++;
          if (obs_wdata === dropped[k]) begin n_fail++; $display("FAIL full_dropped_written: got %h expected not %h", obs_wdata, dropped[k]); end
        end
      end
    end
  endtask

  task automatic test_max_stall0();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      fpu_valid_i = 1'b1; fpu_rd_i = 5'd3; fpu_data_i = 32'hA0 + i;
      mem_valid_i = 1'b1; mem_rd_i = 5'(10 + i); mem_data_i = 32'hB0 + i;
      #2;
      n_checks++;
      if ({z_ready, z_we, z_sbclr, z_wsrc, z_waddr, z_wdata} !== {1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'hA0 + i}) begin
        n_fail++;
        $display("FAIL stall0_fpu cyc%0d: got %h expected %h", i, {z_ready, z_we, z_sbclr, z_wsrc, z_waddr, z_wdata}, {1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'hA0 + i});
      end
      n_checks++;
      if ({z_cnt, z_ovf} !== {2'((i < 2) ? i : 2), (i == 3)}) begin
        n_fail++;
        $display("FAIL stall0_buf cyc%0d: got %b expected %b", i, {z_cnt, z_ovf}, {2'((i < 2) ? i : 2), (i == 3)});
      end
      @(posedge clk);
      @(negedge clk);
    end
    fpu_valid_i = 1'b0; mem_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (i < 2) begin
        if ({z_we, z_wsrc, z_waddr, z_wdata} !== {1'b1, 1'b1, 5'(10 + i), 32'hB0 + i}) begin
          n_fail++;
          $display("FAIL stall0_drain%0d: got %h expected %h", i, {z_we, z_wsrc, z_waddr, z_wdata}, {1'b1, 1'b1, 5'(10 + i), 32'hB0 + i});
        end
      end else if ({z_we, z_cnt} !== 3'b000) begin
        n_fail++;
        $display("FAIL stall0_idle: got %b expected 000", {z_we, z_cnt});
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fd = 32'hE000;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd4, fd, 1'b1, 5'(20 + i), 32'h2000 + i);
      if (e_ready) fd++;
    end
    n_checks++;
    if ({mq.size() == 2, m_stall == 2, mem_buf_cnt_o} !== {1'b1, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got cnt %0d expected 2", mem_buf_cnt_o);
    end
    fpu_valid_i = 1'b1; mem_valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    n_checks++;
    if ({fpr_we_o, fpu_ready_o, mem_buf_cnt_o, mem_buf_full_o, overflow_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected 000000", {fpr_we_o, fpu_ready_o, mem_buf_cnt_o, mem_buf_full_o, overflow_o});
    end
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++;
      if ({obs_we, obs_cnt} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_nowrite%0d: got %b expected 000", i, {obs_we, obs_cnt}); end
    end
  endtask

  task automatic test_random();
    logic        pend = 1'b0, mv;
    logic [4:0]  frd = '0, mrd;
    logic [31:0] fd = '0, md;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(9, 0) < 6) begin
        pend = 1'b1; frd = 5'($urandom()); fd = $urandom();
      end
      mv  = ($urandom_range(1, 0) == 1);
      mrd = 5'($urandom());
      md  = $urandom();
      step(pend, frd, fd, mv, mrd, md);
      if (e_ready) pend = 1'b0;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_vec cyc%0d: got %h expected %h", i, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lone_load();
    test_collision();
    test_buffering();
    test_full();
    test_max_stall0();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
